// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl
//   Transmit-side controller for a UART. It sits directly upstream of an external
//   FRAME_BITS-wide parallel-in/serial-out right-shift register.
//   - A byte is accepted through a ready/valid handshake.
//   - The controller builds the full frame: start, data LSB-first, parity, stop.
//   - It pulses `load` once to hand the frame to the shift register.
//   - It then pulses `shift` once per baud period, so the register's LSB walks the
//     frame out onto the line.
//   - A one-cycle `tx_done` pulse marks the end of the frame.
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   tx_start  in   valid: request to send tx_data (only looked at while idle)
//   tx_data   in   payload byte, sampled on accept
//   tx_ready  out  high while idle and able to accept
//   frame     out  parallel frame to the shift register D input (all ones after reset)
//   load      out  parallel-load strobe for the shift register
//   shift     out  shift strobe for the shift register
//   tx_done   out  one-cycle pulse once the stop bit has been fully sent

module uart_tx_ctrl #(
   parameter int unsigned  DATA_BITS  = 8,
   parameter int unsigned  BAUD_DIV   = 5208,
   parameter bit           PARITY_ODD = 1'b0,
   localparam int unsigned FRAME_BITS = DATA_BITS + 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  tx_start,
   input  logic [DATA_BITS-1:0]  tx_data,
   output logic                  tx_ready,
   output logic [FRAME_BITS-1:0] frame,
   output logic                  load,
   output logic                  shift,
   output logic                  tx_done
);

   localparam int unsigned BAUD_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam int unsigned BIT_W  = $clog2(FRAME_BITS);

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(FRAME_BITS - 1);

   typedef enum logic [1:0] {
      StIdle,
      StLoad,
      StSend,
      StDone
   } state_e;

   state_e                state_q, state_d;
   logic [FRAME_BITS-1:0] frame_q, frame_d;
   logic [BAUD_W-1:0]     baud_cnt_q, baud_cnt_d;
   logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;

   logic                  parity_bit;
   logic                  baud_tick;

   // PARITY_ODD inverts the even-parity XOR reduction.
   assign parity_bit = (^tx_data) ^ PARITY_ODD;
   assign baud_tick  = (baud_cnt_q == BAUD_LAST);

   //------------------------------------------------------------------
   // Moore outputs, except shift, which also needs the baud terminal count
   //------------------------------------------------------------------
   always_comb begin
      tx_ready = 1'b0;
      load     = 1'b0;
      shift    = 1'b0;
      tx_done  = 1'b0;
      unique case (state_q)
         StIdle:  tx_ready = 1'b1;
         StLoad:  load     = 1'b1;
         StSend:  shift    = baud_tick;
         StDone:  tx_done  = 1'b1;
         default: ;
      endcase
   end

   //------------------------------------------------------------------
   // Next-state logic
   //------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      frame_d    = frame_q;
      baud_cnt_d = baud_cnt_q;
      bit_cnt_d  = bit_cnt_q;

      unique case (state_q)
         StIdle: begin
            if (tx_start) begin
               // Bit 0 leaves the shift register first, so the start bit sits at the LSB.
               frame_d = {1'b1, parity_bit, tx_data, 1'b0};
               state_d = StLoad;
            end
         end

         StLoad: begin
            baud_cnt_d = '0;
            bit_cnt_d  = '0;
            state_d    = StSend;
         end

         StSend: begin
            if (baud_tick) begin
               baud_cnt_d = '0;
               if (bit_cnt_q == BIT_LAST) begin
                  // That was the shift that pushes the stop bit out; the line is back to 1s.
                  bit_cnt_d = '0;
                  state_d   = StDone;
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_W'(1);
               end
            end else begin
               baud_cnt_d = baud_cnt_q + BAUD_W'(1);
            end
         end

         StDone: begin
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   //------------------------------------------------------------------
   // State register
   //------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         frame_q    <= '1;
         baud_cnt_q <= '0;
         bit_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         frame_q    <= frame_d;
         baud_cnt_q <= baud_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
      end
   end

   assign frame = frame_q;

   //------------------------------------------------------------------
   // Invariants
   //------------------------------------------------------------------
   a_no_load_with_shift : assert property (@(posedge clk) disable iff (rst)
      !(load && shift));

   a_baud_cnt_range : assert property (@(posedge clk) disable iff (rst)
      baud_cnt_q <= BAUD_LAST);

   a_bit_cnt_range : assert property (@(posedge clk) disable iff (rst)
      bit_cnt_q <= BIT_LAST);

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl
//   Directed bench for uart_tx_ctrl with BAUD_DIV=4. Two instances share stimulus:
//   one with even parity, one with odd parity. A reference shift register, driven
//   by the even instance's load/shift strobes, produces the serial line. Each frame
//   is recorded cycle by cycle, with cycle 0 being the cycle after the accept edge.
//   The recorded trace is then compared against hand-computed frames and timing.

module tb_uart_tx_ctrl;

   localparam int unsigned BAUD = 4;
   localparam int          NREC = 128;

   logic        clk      = 1'b0;
   logic        rst      = 1'b1;
   logic        tx_start = 1'b0;
   logic [7:0]  tx_data  = 8'h00;

   logic        ready_e, load_e, shift_e, done_e;
   logic [10:0] frame_e;
   logic        ready_o, load_o, shift_o, done_o;
   logic [10:0] frame_o;

   always #5 clk = ~clk;

   uart_tx_ctrl #(
      .DATA_BITS  (8),
      .BAUD_DIV   (BAUD),
      .PARITY_ODD (1'b0)
   ) u_dut_even (
      .clk      (clk),
      .rst      (rst),
      .tx_start (tx_start),
      .tx_data  (tx_data),
      .tx_ready (ready_e),
      .frame    (frame_e),
      .load     (load_e),
      .shift    (shift_e),
      .tx_done  (done_e)
   );

   uart_tx_ctrl #(
      .DATA_BITS  (8),
      .BAUD_DIV   (BAUD),
      .PARITY_ODD (1'b1)
   ) u_dut_odd (
      .clk      (clk),
      .rst      (rst),
      .tx_start (tx_start),
      .tx_data  (tx_data),
      .tx_ready (ready_o),
      .frame    (frame_o),
      .load     (load_o),
      .shift    (shift_o),
      .tx_done  (done_o)
   );

   // Reference shift register; its LSB is the serial line.
   logic [10:0] sr;
   always @(posedge clk) begin
      if (rst)          sr <= '1;
      else if (load_e)  sr <= frame_e;
      else if (shift_e) sr <= {1'b1, sr[10:1]};
   end

   // Cycle-by-cycle recording.
   logic [NREC-1:0] rec_load, rec_shift, rec_done, rec_ready, rec_line;
   logic [10:0]     rec_frame   [NREC];
   logic [10:0]     rec_frame_o [NREC];
   int              lock_err = 0;

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic clear_rec();
      rec_load  = '0;
      rec_shift = '0;
      rec_done  = '0;
      rec_ready = '0;
      rec_line  = '0;
      for (int i = 0; i < NREC; i++) begin
         rec_frame[i]   = '0;
         rec_frame_o[i] = '0;
      end
   endtask

   task automatic sample(input int c);
      rec_load[c]    = load_e;
      rec_shift[c]   = shift_e;
      rec_done[c]    = done_e;
      rec_ready[c]   = ready_e;
      rec_line[c]    = sr[0];
      rec_frame[c]   = frame_e;
      rec_frame_o[c] = frame_o;
      // Parity setting must not change any timing.
      if ({load_o, shift_o, done_o, ready_o} !== {load_e, shift_e, done_e, ready_e})
         lock_err++;
   endtask

   function automatic int count(input logic [NREC-1:0] v, input int lo, input int hi);
      int n = 0;
      for (int c = lo; c <= hi; c++) if (v[c] === 1'b1) n++;
      return n;
   endfunction

   // Line bit b is expected during cycles base+1+BAUD*b .. base+BAUD*(b+1).
   function automatic int line_errs(input int base, input logic [10:0] exp);
      int errs = 0;
      for (int c = base + 1; c <= base + 11 * BAUD; c++)
         if (rec_line[c] !== exp[(c - base - 1) / BAUD]) errs++;
      return errs;
   endfunction

   function automatic int shift_bad(input int base, input int hi);
      int bad = 0;
      for (int c = base; c <= hi; c++) begin
         int r;
         r = c - base;
         if (rec_shift[c] === 1'b1 && !(r >= BAUD && r <= 11 * BAUD && (r % BAUD) == 0))
            bad++;
      end
      return bad;
   endfunction

   // Sends one byte with a 1-cycle tx_start. A poke_at >= 0 pulses tx_start with
   // 8'h3C at that cycle to show that a busy controller ignores it.
   task automatic run_one(input logic [7:0] d, input logic [10:0] exp_e,
                          input logic [10:0] exp_o, input int poke_at, input string tag);
      clear_rec();
      @(negedge clk);
      chk({tag, ":ready_before"}, 32'(ready_e), 32'd1);
      tx_start = 1'b1;
      tx_data  = d;
      @(negedge clk);
      for (int c = 0; c < 48; c++) begin
         sample(c);
         if (c == 0) tx_start = 1'b0;
         if (c == poke_at) begin
            tx_start = 1'b1;
            tx_data  = 8'h3C;
         end
         if (poke_at >= 0 && c == poke_at + 1) tx_start = 1'b0;
         @(negedge clk);
      end
      chk({tag, ":frame_even"},  32'(rec_frame[0]),   32'(exp_e));
      chk({tag, ":frame_odd"},   32'(rec_frame_o[0]), 32'(exp_o));
      chk({tag, ":load_at0"},    32'(rec_load[0]),    32'd1);
      chk({tag, ":load_count"},  32'(count(rec_load, 0, 47)), 32'd1);
      chk({tag, ":ready_busy"},  32'(count(rec_ready, 0, 45)), 32'd0);
      chk({tag, ":ready_at46"},  32'(rec_ready[46]),  32'd1);
      chk({tag, ":shift_count"}, 32'(count(rec_shift, 0, 47)), 32'd11);
      chk({tag, ":shift_place"}, 32'(shift_bad(0, 47)), 32'd0);
      chk({tag, ":done_count"},  32'(count(rec_done, 0, 47)), 32'd1);
      chk({tag, ":done_at45"},   32'(rec_done[45]),   32'd1);
      chk({tag, ":line_bits"},   32'(line_errs(0, exp_e)), 32'd0);
      chk({tag, ":line_idle"},   32'(count(rec_line, 45, 47)), 32'd3);
      chk({tag, ":frame_held"},  32'(rec_frame[47]),  32'(exp_e));
   endtask

   typedef struct {
      logic [7:0]  data;
      logic [10:0] exp_even;
      logic [10:0] exp_odd;
   } vec_t;

   vec_t vecs [6];

   initial begin
      vecs[0] = '{data: 8'hA5, exp_even: 11'h54A, exp_odd: 11'h74A};
      vecs[1] = '{data: 8'h01, exp_even: 11'h602, exp_odd: 11'h402};
      vecs[2] = '{data: 8'hFF, exp_even: 11'h5FE, exp_odd: 11'h7FE};
      vecs[3] = '{data: 8'h3C, exp_even: 11'h478, exp_odd: 11'h678};
      vecs[4] = '{data: 8'h80, exp_even: 11'h700, exp_odd: 11'h500};
      vecs[5] = '{data: 8'h00, exp_even: 11'h400, exp_odd: 11'h600};

      // Reset held for 2 cycles.
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst:ready",     32'(ready_e), 32'd1);
      chk("rst:load",      32'(load_e),  32'd0);
      chk("rst:shift",     32'(shift_e), 32'd0);
      chk("rst:done",      32'(done_e),  32'd0);
      chk("rst:frame",     32'(frame_e), 32'h7FF);
      chk("rst:frame_odd", 32'(frame_o), 32'h7FF);
      chk("rst:ready_odd", 32'(ready_o), 32'd1);
      rst = 1'b0;

      // Table-driven single frames.
      for (int i = 0; i < 6; i++)
         run_one(vecs[i].data, vecs[i].exp_even, vecs[i].exp_odd, -1,
                 $sformatf("vec%0d", i));

      // tx_start pulsed with another byte during SEND.
      run_one(8'hA5, 11'h54A, 11'h74A, 12, "busy");

      // Back-to-back: tx_start held across DONE.
      clear_rec();
      @(negedge clk);
      tx_start = 1'b1;
      tx_data  = 8'h55;
      @(negedge clk);
      for (int c = 0; c < 100; c++) begin
         sample(c);
         if (c == 0)  tx_data  = 8'hAA;
         if (c == 47) tx_start = 1'b0;
         @(negedge clk);
      end
      chk("b2b:frame1",      32'(rec_frame[0]),  32'h4AA);
      chk("b2b:frame2",      32'(rec_frame[47]), 32'h554);
      chk("b2b:load2_at47",  32'(rec_load[47]),  32'd1);
      chk("b2b:load_count",  32'(count(rec_load, 0, 99)), 32'd2);
      chk("b2b:done1_at45",  32'(rec_done[45]),  32'd1);
      chk("b2b:done2_at92",  32'(rec_done[92]),  32'd1);
      chk("b2b:done_count",  32'(count(rec_done, 0, 99)), 32'd2);
      chk("b2b:line1",       32'(line_errs(0, 11'h4AA)), 32'd0);
      chk("b2b:line2",       32'(line_errs(47, 11'h554)), 32'd0);
      chk("b2b:line_gap",    32'(count(rec_line, 45, 47)), 32'd3);
      chk("b2b:shift_count", 32'(count(rec_shift, 0, 99)), 32'd22);
      chk("b2b:shift_place", 32'(shift_bad(0, 46) + shift_bad(47, 99)), 32'd0);
      chk("b2b:ready_at93",  32'(rec_ready[93]), 32'd1);

      // Reset on the 5th shift pulse.
      clear_rec();
      @(negedge clk);
      tx_start = 1'b1;
      tx_data  = 8'hA5;
      @(negedge clk);
      for (int c = 0; c < 80; c++) begin
         sample(c);
         if (c == 0)  tx_start = 1'b0;
         if (c == 20) rst = 1'b1;
         if (c == 21) rst = 1'b0;
         @(negedge clk);
      end
      chk("midrst:fifth_shift", 32'(rec_shift[20]), 32'd1);
      chk("midrst:shifts_pre",  32'(count(rec_shift, 0, 20)), 32'd5);
      chk("midrst:ready",       32'(rec_ready[21]), 32'd1);
      chk("midrst:load",        32'(rec_load[21]),  32'd0);
      chk("midrst:shift",       32'(rec_shift[21]), 32'd0);
      chk("midrst:frame",       32'(rec_frame[21]), 32'h7FF);
      chk("midrst:no_shift",    32'(count(rec_shift, 21, 79)), 32'd0);
      chk("midrst:no_done",     32'(count(rec_done, 0, 79)), 32'd0);
      chk("midrst:no_load",     32'(count(rec_load, 1, 79)), 32'd0);
      chk("midrst:line_idle",   32'(count(rec_line, 22, 79)), 32'd58);
      run_one(8'hFF, 11'h5FE, 11'h7FE, -1, "after_rst");

      chk("parity_timing_lock", 32'(lock_err), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
